// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_serial_adder_pkg;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  DIGIT_MAX  = 4'd9;
  localparam logic [3:0]  CORRECTION = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the serial BCD adder with start/done handshake.
interface bcd_serial_adder_if
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                        start;
  logic                        sub;
  logic [DIGIT_W*DIGITS-1:0]   a;
  logic [DIGIT_W*DIGITS-1:0]   b;
  logic                        cin;
  logic                        busy;
  logic                        done;
  logic [DIGIT_W*DIGITS-1:0]   sum;
  logic                        cout;
  logic                        invalid;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, invalid
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, invalid
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder cell: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_adder
  import bcd_serial_adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic [DIGIT_W:0] bin;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    s   = '0;
    co  = 1'b0;
    bin = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
    if (bin > {1'b0, DIGIT_MAX}) begin
      s  = bin[DIGIT_W-1:0] + CORRECTION;
      co = 1'b1;
    end else begin
      s  = bin[DIGIT_W-1:0];
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, one shared digit cell.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  bcd_serial_adder_if.slave bus
);

  localparam int                W     = DIGIT_W * DIGITS;
  localparam int                IDX_W = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               sub_q;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               cout_q, invalid_q;

  logic               accept;
  logic               any_bad;
  logic [DIGIT_W-1:0] b_dig, s_dig;
  logic               co_dig;

  assign accept = bus.start && (state_q != ST_RUN);

  // Subtraction uses the nines' complement of b with the carry register preset to 1.
  assign b_dig = sub_q ? (DIGIT_MAX - b_q[DIGIT_W-1:0]) : b_q[DIGIT_W-1:0];

  bcd_digit_adder u_cell (
    .a  (a_q[DIGIT_W-1:0]),
    .b  (b_dig),
    .ci (carry_q),
    .s  (s_dig),
    .co (co_dig)
  );

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX || bus.b[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX)
        any_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST) state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else if (accept) begin
      idx_q     <= '0;
      carry_q   <= bus.sub | bus.cin;
      sub_q     <= bus.sub;
      a_q       <= bus.a;
      b_q       <= bus.b;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= any_bad;
    end else if (state_q == ST_RUN) begin
      // Operands shift down so the active digit always sits in the low nibble.
      a_q     <= a_q >> DIGIT_W;
      b_q     <= b_q >> DIGIT_W;
      carry_q <= co_dig;
      idx_q   <= idx_q + 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) sum_q[i*DIGIT_W +: DIGIT_W] <= s_dig;
      end
      if (idx_q == LAST) cout_q <= co_dig;
    end
  end

  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.invalid = invalid_q;

endmodule
